ledm_scan: RTL and testbench
============================

# ledm_scan

Multiplexed scan driver for the 5-column × 8-row LED matrix on the board. It sits directly downstream of the Nios system's LED PIO export and replaces the hard-wired single-column drive. Software writes column patterns into a back buffer and requests a swap. The block scans the front buffer column by column with a blanking gap between columns, and drives the active-low LEDM_C/LEDM_R pins.

## Interface
Parameters:
- COLS, 5, number of matrix columns (LEDM_C width)
- ROWS, 8, number of matrix rows (LEDM_R width)
- DWELL_CYCLES, 50000, clock cycles each column is lit (1 ms at 50 MHz)
- BLANK_CYCLES, 500, clock cycles all columns are off before each column is lit

Ports:
- clock_50MHz  in  1  system clock; sole clock domain
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe, one pattern per cycle
- wr_col  in  3  target column index for the write
- wr_data  in  ROWS  row pattern; 1 = LED on
- swap_req  in  1  single-cycle request to publish the back buffer
- swap_pending  out  1  swap requested, not yet applied
- frame_done  out  1  one-cycle pulse at each frame wrap
- LEDM_C  out  COLS  column select, active low
- LEDM_R  out  ROWS  row drive, active low

## Operation
- Two buffers, each holding COLS × ROWS bits: back (written by software) and front (displayed). Both clear to 0 on reset.
- Write: when wr_en=1 and wr_col<COLS, back[wr_col] ← wr_data. Writes with wr_col≥COLS are ignored.
- FSM states are BLANK and DRIVE; the column index col counts 0..COLS-1.
  - BLANK: LEDM_C and LEDM_R are all ones. After BLANK_CYCLES cycles the FSM moves to DRIVE.
  - DRIVE: LEDM_C has only bit col at 0, and LEDM_R = ~front[col]. After DWELL_CYCLES cycles the FSM moves to BLANK, and col advances.
- Column wrap: col advances from COLS-1 to 0. On that DRIVE→BLANK transition:
  - frame_done pulses high for one cycle.
  - If swap_pending=1, front ← back (a copy, so back keeps its content) and swap_pending clears.
- swap_req sets swap_pending. If swap_req arrives on the same cycle as the wrap, it applies at the next wrap, not the current one.
- A write on the same cycle as a swap lands in back. The copy takes back's pre-write value, so the new pattern appears one frame later.
- front is never modified mid-frame, so the display does not tear.
- Asserting reset_n low mid-scan has these effects immediately:
  - all outputs go high and the buffers clear;
  - state = BLANK, col = 0, counters = 0, swap_pending = 0.

## Timing
- Reset values: LEDM_C = all 1, LEDM_R = all 1, swap_pending = 0, frame_done = 0.
- All outputs are registered.
- After reset is released:
  - cycles 0..BLANK_CYCLES-1 are blank;
  - column 0 is lit for cycles BLANK_CYCLES..BLANK_CYCLES+DWELL_CYCLES-1.
- Frame period = COLS × (BLANK_CYCLES + DWELL_CYCLES) cycles. With the defaults this is 252 500 cycles, about 198 Hz.
- frame_done is high on the first BLANK cycle after column COLS-1. The swapped front buffer is visible from column 0 of the following DRIVE.
- Write latency into back is 1 cycle. Display latency is at most 2 frames after swap_req.
- The dwell counter width is clog2(max(DWELL_CYCLES, BLANK_CYCLES)). The counter reloads to 0 on each state change and never wraps inside a state.

## Structure
- Shared package ledm_pkg holds:
  - COLS and ROWS constants;
  - the scan state enum {BLANK, DRIVE};
  - the column-index width.
- Sub-module ledm_framebuf holds the back and front arrays. It implements the write port, the copy-on-swap, and a combinational read port front[col].
- The top level holds the FSM, the counters, swap_pending and the output registers.
- It is instantiated between the Nios PIO export and the board pins.

## Test plan
Bench parameters: DWELL_CYCLES=4, BLANK_CYCLES=2.
- Reset then idle:
  - outputs all ones for 2 cycles;
  - then LEDM_C=5'b11110 and LEDM_R=8'hFF for 4 cycles;
  - then blank, then LEDM_C=5'b11101;
  - col 4 is followed by col 0, with frame_done pulsing every 30 cycles.
- Write back[2]=8'hA5, then swap_req mid-frame:
  - no display change in the current frame;
  - swap_pending clears at the wrap;
  - in the next frame, col 2 drives LEDM_R=8'h5A and the other columns drive 8'hFF.
- Write with wr_col=5 and 7, data 8'hFF, then swap: the display is unchanged (all 8'hFF on LEDM_R).
- swap_req on the exact wrap cycle: the old front is shown for one more frame; the swap applies at the following wrap.
- Write back[0]=8'h01 together with a swap on the same cycle: the front gets the old back[0]; the next swap shows LEDM_R=8'hFE on col 0.
- reset_n low in the middle of col 3 DRIVE:
  - outputs go high the same cycle and buffers read 0;
  - after release, the scan restarts at BLANK then col 0.

Source files
------------

// File: rtl/ledm_pkg.sv
// rtl/ledm_pkg.sv - shared constants and scan state type for the LED matrix scan driver
package ledm_pkg;
    localparam int DEF_COLS = 5;
    localparam int DEF_ROWS = 8;
    localparam int COL_W    = 3;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;
endpackage

// File: rtl/ledm_framebuf.sv
// rtl/ledm_framebuf.sv - back/front pattern buffers with write port, copy-on-swap and front read port
module ledm_framebuf
    import ledm_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_col,
    input  logic [ROWS-1:0]  wr_data,
    input  logic             copy,
    input  logic [COL_W-1:0] rd_col,
    output logic [ROWS-1:0]  rd_data
);
    logic [ROWS-1:0] back  [COLS];
    logic [ROWS-1:0] front [COLS];

    // Copy and write share an edge: front takes back's value from before the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < COLS; i++) begin
                back[i]  <= '0;
                front[i] <= '0;
            end
        end else begin
            if (copy) begin
                for (int i = 0; i < COLS; i++) begin
                    front[i] <= back[i];
                end
            end
            if (wr_en && (int'(wr_col) < COLS)) begin
                back[wr_col] <= wr_data;
            end
        end
    end

    assign rd_data = (int'(rd_col) < COLS) ? front[rd_col] : '0;
endmodule

// File: rtl/ledm_scan.sv
// rtl/ledm_scan.sv - multiplexed column scan of a double-buffered LED matrix with blanking gaps
module ledm_scan
    import ledm_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic             clock_50MHz,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_col,
    input  logic [ROWS-1:0]  wr_data,
    input  logic             swap_req,
    output logic             swap_pending,
    output logic             frame_done,
    output logic [COLS-1:0]  LEDM_C,
    output logic [ROWS-1:0]  LEDM_R
);
    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [COL_W-1:0] col;
    logic [ROWS-1:0]  front_col;
    logic             blank_done;
    logic             dwell_done;
    logic             last_col;
    logic             wrap;
    logic             copy;

    assign blank_done = (cnt == CNT_W'(BLANK_CYCLES - 1));
    assign dwell_done = (cnt == CNT_W'(DWELL_CYCLES - 1));
    assign last_col   = (col == COL_W'(COLS - 1));
    assign wrap       = (state == DRIVE) && dwell_done && last_col;
    // Swap only at the frame boundary so a displayed frame never mixes old and new patterns.
    assign copy       = wrap && swap_pending;

    ledm_framebuf #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_framebuf (
        .clk     (clock_50MHz),
        .rst_n   (reset_n),
        .wr_en   (wr_en),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .copy    (copy),
        .rd_col  (col),
        .rd_data (front_col)
    );

    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= BLANK;
            cnt          <= '0;
            col          <= '0;
            swap_pending <= 1'b0;
            frame_done   <= 1'b0;
            LEDM_C       <= '1;
            LEDM_R       <= '1;
        end else begin
            frame_done <= 1'b0;
            // A request landing on the wrap edge survives the clear and waits for the next wrap.
            if (swap_req) begin
                swap_pending <= 1'b1;
            end else if (copy) begin
                swap_pending <= 1'b0;
            end

            case (state)
                BLANK: begin
                    if (blank_done) begin
                        state  <= DRIVE;
                        cnt    <= '0;
                        LEDM_C <= ~(COLS'(1) << col);
                        LEDM_R <= ~front_col;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (dwell_done) begin
                        state      <= BLANK;
                        cnt        <= '0;
                        LEDM_C     <= '1;
                        LEDM_R     <= '1;
                        col        <= last_col ? '0 : col + 1'b1;
                        frame_done <= last_col;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ledm_scan.sv
// tb/tb_ledm_scan.sv - directed self-checking bench for ledm_scan with DWELL_CYCLES=4, BLANK_CYCLES=2
module tb_ledm_scan;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [2:0] wr_col;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_pending;
    logic       frame_done;
    logic [4:0] LEDM_C;
    logic [7:0] LEDM_R;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] fexp [5];
    logic [7:0] bexp [5];
    logic       pend_m;

    always #5 clk = ~clk;

    ledm_scan #(
        .COLS         (5),
        .ROWS         (8),
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clock_50MHz  (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .frame_done   (frame_done),
        .LEDM_C       (LEDM_C),
        .LEDM_R       (LEDM_R)
    );

    // Slot of 6 cycles per column: 2 blank then 4 lit; 30-cycle frame.
    function automatic logic [4:0] exp_c(int k);
        if ((k % 6) < 2) return 5'h1F;
        return ~(5'b00001 << ((k / 6) % 5));
    endfunction

    function automatic logic [7:0] exp_r(int k);
        if ((k % 6) < 2) return 8'hFF;
        return ~fexp[(k / 6) % 5];
    endfunction

    function automatic logic exp_fd(int k);
        return (k > 0) && ((k % 30) == 0);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 5; i++) begin
            fexp[i] = 8'h00;
            bexp[i] = 8'h00;
        end
        pend_m = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        if (((cyc % 30) == 29) && pend_m) begin
            for (int i = 0; i < 5; i++) fexp[i] = bexp[i];
            pend_m = 1'b0;
        end
        if (wr_en && (wr_col < 3'd5)) bexp[wr_col] = wr_data;
        if (swap_req) pend_m = 1'b1;
        @(negedge clk);
        cyc++;
        wr_en    = 1'b0;
        swap_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_en = 1'b0; wr_col = 3'd0; wr_data = 8'h00; swap_req = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        checks++; if (LEDM_C !== 5'h1F) begin errors++; $display("FAIL reset_ledm_c got=%b exp=%b", LEDM_C, 5'h1F); end
        checks++; if (LEDM_R !== 8'hFF) begin errors++; $display("FAIL reset_ledm_r got=%h exp=%h", LEDM_R, 8'hFF); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_swap_pending got=%b exp=0", swap_pending); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_idle();
        while (cyc < 61) begin
            step();
            checks++; if (LEDM_C !== exp_c(cyc)) begin errors++; $display("FAIL idle_ledm_c cyc=%0d got=%b exp=%b", cyc, LEDM_C, exp_c(cyc)); end
            checks++; if (LEDM_R !== exp_r(cyc)) begin errors++; $display("FAIL idle_ledm_r cyc=%0d got=%h exp=%h", cyc, LEDM_R, exp_r(cyc)); end
            checks++; if (frame_done !== exp_fd(cyc)) begin errors++; $display("FAIL idle_frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd(cyc)); end
            if (cyc == 2) begin checks++; if (LEDM_C !== 5'b11110) begin errors++; $display("FAIL idle_col0 got=%b exp=11110", LEDM_C); end end
            if (cyc == 8) begin checks++; if (LEDM_C !== 5'b11101) begin errors++; $display("FAIL idle_col1 got=%b exp=11101", LEDM_C); end end
            if (cyc == 30) begin checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL idle_wrap_pulse got=%b exp=1", frame_done); end end
        end
    endtask

    task automatic test_swap();
        while (cyc < 120) begin
            if (cyc == 62) begin wr_en = 1'b1; wr_col = 3'd2; wr_data = 8'hA5; end
            if (cyc == 65) swap_req = 1'b1;
            step();
            checks++; if (LEDM_C !== exp_c(cyc)) begin errors++; $display("FAIL swap_ledm_c cyc=%0d got=%b exp=%b", cyc, LEDM_C, exp_c(cyc)); end
            checks++; if (LEDM_R !== exp_r(cyc)) begin errors++; $display("FAIL swap_ledm_r cyc=%0d got=%h exp=%h", cyc, LEDM_R, exp_r(cyc)); end
            checks++; if (swap_pending !== pend_m) begin errors++; $display("FAIL swap_pending cyc=%0d got=%b exp=%b", cyc, swap_pending, pend_m); end
            if (cyc == 66) begin checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL swap_set got=%b exp=1", swap_pending); end end
            if (cyc == 74) begin checks++; if (LEDM_R !== 8'hFF) begin errors++; $display("FAIL swap_no_tear got=%h exp=ff", LEDM_R); end end
            if (cyc == 90) begin checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL swap_cleared got=%b exp=0", swap_pending); end end
            if (cyc == 104) begin checks++; if (LEDM_R !== 8'h5A) begin errors++; $display("FAIL swap_visible got=%h exp=5a", LEDM_R); end end
        end
    endtask

    task automatic test_bad_col();
        while (cyc < 180) begin
            if (cyc == 122) begin wr_en = 1'b1; wr_col = 3'd5; wr_data = 8'hFF; end
            if (cyc == 123) begin wr_en = 1'b1; wr_col = 3'd7; wr_data = 8'hFF; end
            if (cyc == 125) swap_req = 1'b1;
            step();
            checks++; if (LEDM_C !== exp_c(cyc)) begin errors++; $display("FAIL badcol_ledm_c cyc=%0d got=%b exp=%b", cyc, LEDM_C, exp_c(cyc)); end
            checks++; if (LEDM_R !== exp_r(cyc)) begin errors++; $display("FAIL badcol_ledm_r cyc=%0d got=%h exp=%h", cyc, LEDM_R, exp_r(cyc)); end
            if (cyc == 158) begin checks++; if (LEDM_R !== 8'hFF) begin errors++; $display("FAIL badcol_col1 got=%h exp=ff", LEDM_R); end end
            if (cyc == 164) begin checks++; if (LEDM_R !== 8'h5A) begin errors++; $display("FAIL badcol_col2 got=%h exp=5a", LEDM_R); end end
        end
    endtask

    task automatic test_swap_on_wrap();
        while (cyc < 260) begin
            if (cyc == 185) begin wr_en = 1'b1; wr_col = 3'd1; wr_data = 8'h3C; end
            if (cyc == 209) swap_req = 1'b1;
            step();
            checks++; if (LEDM_R !== exp_r(cyc)) begin errors++; $display("FAIL wrapswap_ledm_r cyc=%0d got=%h exp=%h", cyc, LEDM_R, exp_r(cyc)); end
            checks++; if (frame_done !== exp_fd(cyc)) begin errors++; $display("FAIL wrapswap_frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd(cyc)); end
            if (cyc == 210) begin checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL wrapswap_pending got=%b exp=1", swap_pending); end end
            if (cyc == 218) begin checks++; if (LEDM_R !== 8'hFF) begin errors++; $display("FAIL wrapswap_old_front got=%h exp=ff", LEDM_R); end end
            if (cyc == 240) begin checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL wrapswap_cleared got=%b exp=0", swap_pending); end end
            if (cyc == 248) begin checks++; if (LEDM_R !== 8'hC3) begin errors++; $display("FAIL wrapswap_new_front got=%h exp=c3", LEDM_R); end end
        end
    endtask

    task automatic test_write_with_swap();
        while (cyc < 310) begin
            if (cyc == 262) swap_req = 1'b1;
            if (cyc == 269) begin wr_en = 1'b1; wr_col = 3'd0; wr_data = 8'h01; end
            if (cyc == 275) swap_req = 1'b1;
            step();
            checks++; if (LEDM_R !== exp_r(cyc)) begin errors++; $display("FAIL wrwswap_ledm_r cyc=%0d got=%h exp=%h", cyc, LEDM_R, exp_r(cyc)); end
            checks++; if (swap_pending !== pend_m) begin errors++; $display("FAIL wrwswap_pending cyc=%0d got=%b exp=%b", cyc, swap_pending, pend_m); end
            if (cyc == 272) begin checks++; if (LEDM_R !== 8'hFF) begin errors++; $display("FAIL wrwswap_old_back got=%h exp=ff", LEDM_R); end end
            if (cyc == 302) begin checks++; if (LEDM_R !== 8'hFE) begin errors++; $display("FAIL wrwswap_next_swap got=%h exp=fe", LEDM_R); end end
        end
    endtask

    task automatic test_reset_mid();
        while (cyc < 321) begin
            if (cyc == 312) swap_req = 1'b1;
            step();
        end
        checks++; if (LEDM_C !== 5'b10111) begin errors++; $display("FAIL midreset_pre_col3 got=%b exp=10111", LEDM_C); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (LEDM_C !== 5'h1F) begin errors++; $display("FAIL midreset_ledm_c got=%b exp=11111", LEDM_C); end
        checks++; if (LEDM_R !== 8'hFF) begin errors++; $display("FAIL midreset_ledm_r got=%h exp=ff", LEDM_R); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL midreset_pending got=%b exp=0", swap_pending); end
        @(negedge clk);
        reset_n = 1'b1;
        clear_model();
        cyc = 0;
        while (cyc < 35) begin
            step();
            checks++; if (LEDM_C !== exp_c(cyc)) begin errors++; $display("FAIL restart_ledm_c cyc=%0d got=%b exp=%b", cyc, LEDM_C, exp_c(cyc)); end
            checks++; if (LEDM_R !== exp_r(cyc)) begin errors++; $display("FAIL restart_ledm_r cyc=%0d got=%h exp=%h", cyc, LEDM_R, exp_r(cyc)); end
            if (cyc == 1) begin checks++; if (LEDM_C !== 5'h1F) begin errors++; $display("FAIL restart_blank got=%b exp=11111", LEDM_C); end end
            if (cyc == 2) begin checks++; if (LEDM_C !== 5'b11110) begin errors++; $display("FAIL restart_col0 got=%b exp=11110", LEDM_C); end end
            if (cyc == 14) begin checks++; if (LEDM_R !== 8'hFF) begin errors++; $display("FAIL restart_buf_clear got=%h exp=ff", LEDM_R); end end
            if (cyc == 30) begin checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL restart_wrap got=%b exp=1", frame_done); end end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_swap();
        test_bad_col();
        test_swap_on_wrap();
        test_write_with_swap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
